// File: rtl/tessia_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tessia_arb_pkg
// Shared types and constants for the TessiaX64 data-memory arbiter.
//   arb_state_t : arbiter FSM states
//   CNT_W       : width of the memory-latency wait counter
//   PERF_W      : width of each performance counter
//   satInc      : saturating increment for performance counters
// ---------------------------------------------------------------------------
package tessia_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int CNT_W  = 8;
  localparam int PERF_W = 32;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tessia_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// tessia_mem_arbiter_if
// Bundles the requester-side load/store signals and the data-RAM port.
//   slave  : arbiter view (samples requests and mem_rdata, drives the rest)
//   master : environment view (requesters plus memory)
// Requester i occupies slice i of the packed req_addr / req_wdata vectors.
// ---------------------------------------------------------------------------
interface tessia_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      mem_re;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ack, resp_valid, resp_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ack, resp_valid, resp_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tessia_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority pick.
//   req    : request vector
//   rrPtr  : index with highest priority this round (must be < NUM_REQ)
//   winner : first set bit at or above rrPtr, wrapping modulo NUM_REQ
//   found  : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
  import tessia_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rrPtr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);
  int             s;
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down to zero so the nearest request
  // (smallest offset from rrPtr) is the last assignment and wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    s      = 0;
    idx    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      s = int'(rrPtr) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = ID_W'(s);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tessia_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tessia_mem_arbiter
// Round-robin arbiter sharing the single data-memory port between NUM_REQ
// requesters, one transaction at a time (IDLE -> ISSUE -> [WAIT] -> RESP).
//   clk, reset : clock and asynchronous active-high reset
//   bus        : requester handshake + memory port (tessia_mem_arbiter_if)
//   busy       : FSM is not in IDLE
// Optional feature (macro TESSIA_ARB_PERF_EN): per-requester saturating
// 32-bit grant and stall counters on perf_grants / perf_stalls.
// Every output is decoded from the state and latched fields only.
// ---------------------------------------------------------------------------
module tessia_mem_arbiter
  import tessia_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  tessia_mem_arbiter_if.slave     bus,
  output logic                    busy
`ifdef TESSIA_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_W-1:0] perf_grants,
  output logic [NUM_REQ*PERF_W-1:0] perf_stalls
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t        stateReg, stateNext;
  logic [ID_W-1:0]   rrPtrReg, idReg, pickId;
  logic              pickFound;
  logic              writeReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg, rdataReg;
  logic [CNT_W-1:0]  cntReg;
  logic [NUM_REQ-1:0] ackVec, respVec;

  logic [ADDR_W-1:0] addrArr  [NUM_REQ];
  logic [DATA_W-1:0] wdataArr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
    assign addrArr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdataArr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) uPick (
    .req    (bus.req_valid),
    .rrPtr  (rrPtrReg),
    .winner (pickId),
    .found  (pickFound)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      rrPtrReg <= '0;
      idReg    <= '0;
      writeReg <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: if (pickFound) begin
          idReg    <= pickId;
          writeReg <= bus.req_write[pickId];
          addrReg  <= addrArr[pickId];
          wdataReg <= wdataArr[pickId];
          rrPtrReg <= (pickId == ID_W'(NUM_REQ - 1)) ? '0 : pickId + 1'b1;
        end
        ISSUE: cntReg <= CNT_W'(MEM_LAT - 1);
        // The last WAIT cycle is the one with the counter at zero; the
        // memory data is valid on the edge that leaves it.
        WAIT: begin
          if (cntReg == '0) rdataReg <= bus.mem_rdata;
          else              cntReg   <= cntReg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext      = stateReg;
    ackVec         = '0;
    respVec        = '0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.resp_rdata = '0;
    case (stateReg)
      IDLE:  if (pickFound) stateNext = ISSUE;
      ISSUE: begin
        ackVec     = NUM_REQ'(1) << idReg;
        bus.mem_re = ~writeReg;
        bus.mem_we = writeReg;
        stateNext  = writeReg ? RESP : WAIT;
      end
      WAIT:  if (cntReg == '0) stateNext = RESP;
      RESP: begin
        respVec        = NUM_REQ'(1) << idReg;
        bus.resp_rdata = writeReg ? '0 : rdataReg;
        stateNext      = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.req_ack    = ackVec;
  assign bus.resp_valid = respVec;
  assign bus.mem_addr   = addrReg;
  assign bus.mem_wdata  = wdataReg;
  assign busy           = (stateReg != IDLE);

`ifdef TESSIA_ARB_PERF_EN
  logic [PERF_W-1:0] grantCnt [NUM_REQ];
  logic [PERF_W-1:0] stallCnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gPerf
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grantCnt[gi] <= '0;
        stallCnt[gi] <= '0;
      end else begin
        if (ackVec[gi]) grantCnt[gi] <= satInc(grantCnt[gi]);
        if (bus.req_valid[gi] && !ackVec[gi]) stallCnt[gi] <= satInc(stallCnt[gi]);
      end
    end
    assign perf_grants[gi*PERF_W +: PERF_W] = grantCnt[gi];
    assign perf_stalls[gi*PERF_W +: PERF_W] = stallCnt[gi];
  end
`endif

endmodule
